// File: rtl/dz_pkg.sv
// Shared types and constants for the 8x8 red/green dot-matrix scan controller.
package dz_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam logic [ROWS-1:0] ROW_OFF = 8'hFF;
   localparam logic [COLS-1:0] COL_OFF = 8'h00;

   // Scan FSM: blank gap before each row, then the row itself.
   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   // One row of pixels as stored in a frame bank.
   typedef struct packed {
      logic [COLS-1:0] red;
      logic [COLS-1:0] grn;
   } pix_t;

   // Visible scan position: FSM state plus current row index.
   typedef struct packed {
      state_t     state;
      logic [2:0] r;
   } scan_pos_t;

   // Active-low one-hot row select for row r.
   function automatic logic [ROWS-1:0] row_sel(input logic [2:0] r);
      return ~(ROWS'(1) << r);
   endfunction

endpackage

// File: rtl/dz_fb_bank.sv
// One 8-row frame bank: async-cleared register file, one write port and a
// combinational read mux.
module dz_fb_bank
   import dz_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data
);

   pix_t mem [ROWS];

   // Row storage; reset wipes the whole bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROWS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= pix_t'(wr_data);
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-multiplexed scan controller for an 8x8 red/green dot matrix with a
// double-buffered frame store and tear-free swaps at frame boundaries.
//
// Swap handshake: swap_req is a level sampled every clock. When it is seen
// with busy low, busy rises on the next edge and stays high until the swap
// executes; swap_req while busy is ignored. The swap executes at the frame
// boundary (or at the next edge while en is low); busy then drops and
// swap_ack pulses for exactly one cycle. Writes (wr_en) are accepted only
// while busy is low and always land in the back bank.
module dz_scan_ctrl
   import dz_pkg::*;
#(
   parameter int ROW_HOLD = 2,
   parameter int BLANK    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_red,
   input  logic [7:0] wr_grn,
   input  logic       swap_req,
   output logic       busy,
   output logic       swap_ack,
   output logic       frame_start,
   output logic [7:0] row,
   output logic [7:0] colr,
   output logic [7:0] colg
);

   localparam int PH_MAX = (BLANK > ROW_HOLD) ? BLANK : ROW_HOLD;
   localparam int PW     = $clog2(PH_MAX + 1);
   localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK - 1);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(ROW_HOLD - 1);

   scan_pos_t   pos;
   logic [PW-1:0] phase;
   logic        front_sel;     // 0: bank0 is displayed, 1: bank1 is displayed

   logic        wr_ok;
   logic        boundary;
   logic        swap_pending;
   logic        swap_now;
   logic [15:0] rd_b0;
   logic [15:0] rd_b1;
   pix_t        front_pix;

   // The last lit cycle of row 7 closes the frame.
   assign boundary     = en && (pos.state == S_SHOW) && (pos.r == 3'd7) &&
                         (phase == HOLD_LAST);
   assign swap_pending = busy || swap_req;
   // While frozen there is no boundary to wait for, so a pending swap runs now.
   assign swap_now     = swap_pending && (boundary || !en);
   assign wr_ok        = wr_en && !busy;

   dz_fb_bank u_bank0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok && front_sel),
      .wr_addr (wr_addr),
      .wr_data ({wr_red, wr_grn}),
      .rd_addr (pos.r),
      .rd_data (rd_b0)
   );

   dz_fb_bank u_bank1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok && !front_sel),
      .wr_addr (wr_addr),
      .wr_data ({wr_red, wr_grn}),
      .rd_addr (pos.r),
      .rd_data (rd_b1)
   );

   assign front_pix = pix_t'(front_sel ? rd_b1 : rd_b0);

   // Scan FSM plus swap/busy bookkeeping and the registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos.state   <= S_BLANK;
         pos.r       <= 3'd0;
         phase       <= '0;
         front_sel   <= 1'b0;
         busy        <= 1'b0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;

         if (en) begin
            case (pos.state)
               S_BLANK: begin
                  if (phase == BLANK_LAST) begin
                     pos.state <= S_SHOW;
                     phase     <= '0;
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               S_SHOW: begin
                  if (phase == HOLD_LAST) begin
                     pos.state <= S_BLANK;
                     pos.r     <= pos.r + 3'd1;
                     phase     <= '0;
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               default: begin
                  pos.state <= S_BLANK;
                  phase     <= '0;
               end
            endcase
         end

         if (boundary) begin
            frame_start <= 1'b1;
         end

         if (swap_now) begin
            front_sel <= ~front_sel;
            busy      <= 1'b0;
            swap_ack  <= 1'b1;
         end else if (swap_req) begin
            busy <= 1'b1;
         end
      end
   end

   // Moore decode of the display drive; everything dark while disabled.
   always_comb begin
      row  = ROW_OFF;
      colr = COL_OFF;
      colg = COL_OFF;
      if (en && (pos.state == S_SHOW)) begin
         row  = row_sel(pos.r);
         colr = front_pix.red;
         colg = front_pix.grn;
      end
   end

endmodule
